// File: rtl/clock_display_ctrl.sv
// clock_display_ctrl
//   Digital-clock controller. Turns the divider's 1 Hz / 2 Hz / 50 Hz / 1 kHz
//   square waves into single-cycle ticks, keeps BCD HH:MM:SS, debounces two
//   set-time push-buttons and drives a 6-digit multiplexed 7-segment display.
//
// Ports
//   clk_50mhz : system clock (only clock in the block)
//   rst       : asynchronous reset, active-low
//   clk_1hz   : 1 Hz level input (data, not a clock)
//   clk_2hz   : 2 Hz level input, blink rate
//   clk_50hz  : 50 Hz level input, key sample rate
//   clk_1khz  : 1 kHz level input, digit scan rate
//   key_mode  : raw push-button, active-low, cycles RUN -> SET_H -> SET_M
//   key_inc   : raw push-button, active-low, increments the selected field
//   seg       : segments, active-low, seg[7]=dp, seg[6:0]=g..a
//   an        : digit enables, active-low one-hot, an[0]=hours tens
module clock_display_ctrl #(
    parameter int unsigned DEB_SAMPLES = 3,
    parameter int unsigned HOUR_MAX    = 23
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic       clk_1hz,
    input  logic       clk_2hz,
    input  logic       clk_50hz,
    input  logic       clk_1khz,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [7:0] seg,
    output logic [5:0] an
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2
    } state_e;

    localparam logic [3:0] HT_MAX   = 4'(HOUR_MAX / 10);
    localparam logic [3:0] HU_MAX   = 4'(HOUR_MAX % 10);
    localparam logic [2:0] CNT_LAST = 3'(DEB_SAMPLES - 1);

    // ------------------------------------------------------------------
    // Tick generation: 2-flop synchronizer plus delay flop per input.
    // Bit order: 0=1 Hz, 1=2 Hz, 2=50 Hz, 3=1 kHz.
    // ------------------------------------------------------------------
    logic [3:0] in_s1_q, in_s2_q, in_dly_q;
    logic [3:0] tick;

    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            in_s1_q  <= '0;
            in_s2_q  <= '0;
            in_dly_q <= '0;
        end else begin
            in_s1_q  <= {clk_1khz, clk_50hz, clk_2hz, clk_1hz};
            in_s2_q  <= in_s1_q;
            in_dly_q <= in_s2_q;
        end
    end

    assign tick = in_s2_q & ~in_dly_q;

    logic tick_1hz, tick_2hz, tick_50hz, tick_1khz;
    assign tick_1hz  = tick[0];
    assign tick_2hz  = tick[1];
    assign tick_50hz = tick[2];
    assign tick_1khz = tick[3];

    // ------------------------------------------------------------------
    // Debounce. Bit 0 = mode key, bit 1 = inc key. Accepted level starts
    // released (high); a press pulse fires only when low is accepted.
    // ------------------------------------------------------------------
    logic [1:0] key_s1_q, key_s2_q, key_lvl_q, press_q;
    logic [2:0] deb_cnt_q [2];

    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            key_s1_q  <= '1;
            key_s2_q  <= '1;
            key_lvl_q <= '1;
            press_q   <= '0;
            for (int unsigned k = 0; k < 2; k++) begin
                deb_cnt_q[k] <= '0;
            end
        end else begin
            key_s1_q <= {key_inc, key_mode};
            key_s2_q <= key_s1_q;
            for (int unsigned k = 0; k < 2; k++) begin
                press_q[k] <= 1'b0;
                if (tick_50hz) begin
                    if (key_s2_q[k] != key_lvl_q[k]) begin
                        if (deb_cnt_q[k] == CNT_LAST) begin
                            key_lvl_q[k] <= key_s2_q[k];
                            deb_cnt_q[k] <= '0;
                            press_q[k]   <= ~key_s2_q[k];
                        end else begin
                            deb_cnt_q[k] <= deb_cnt_q[k] + 3'd1;
                        end
                    end else begin
                        // an agreeing sample restarts the run of differing ones
                        deb_cnt_q[k] <= '0;
                    end
                end
            end
        end
    end

    logic mode_press, inc_press;
    assign mode_press = press_q[0];
    assign inc_press  = press_q[1];

    // ------------------------------------------------------------------
    // Time arithmetic (combinational helpers for the FSM)
    // ------------------------------------------------------------------
    state_e     state_q;
    logic       phase_q;
    logic [3:0] h_t_q, h_u_q, m_t_q, m_u_q, s_t_q, s_u_q;

    logic [3:0] h_t_inc, h_u_inc, m_t_inc, m_u_inc;
    logic [3:0] h_t_adv, h_u_adv, m_t_adv, m_u_adv, s_t_adv, s_u_adv;

    always_comb begin
        // stand-alone field increments used by set mode (no carry out)
        if (h_t_q == HT_MAX && h_u_q == HU_MAX) begin
            h_t_inc = '0;
            h_u_inc = '0;
        end else if (h_u_q == 4'd9) begin
            h_t_inc = h_t_q + 4'd1;
            h_u_inc = '0;
        end else begin
            h_t_inc = h_t_q;
            h_u_inc = h_u_q + 4'd1;
        end

        if (m_u_q == 4'd9) begin
            m_u_inc = '0;
            m_t_inc = (m_t_q == 4'd5) ? 4'd0 : m_t_q + 4'd1;
        end else begin
            m_u_inc = m_u_q + 4'd1;
            m_t_inc = m_t_q;
        end

        // full one-second advance with carry chain
        h_t_adv = h_t_q;
        h_u_adv = h_u_q;
        m_t_adv = m_t_q;
        m_u_adv = m_u_q;
        s_t_adv = s_t_q;
        s_u_adv = s_u_q + 4'd1;
        if (s_u_q == 4'd9) begin
            s_u_adv = '0;
            s_t_adv = s_t_q + 4'd1;
            if (s_t_q == 4'd5) begin
                s_t_adv = '0;
                m_t_adv = m_t_inc;
                m_u_adv = m_u_inc;
                if (m_t_q == 4'd5 && m_u_q == 4'd9) begin
                    h_t_adv = h_t_inc;
                    h_u_adv = h_u_inc;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode FSM, timekeeping and blink phase
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            phase_q <= 1'b1;
            h_t_q   <= '0;
            h_u_q   <= '0;
            m_t_q   <= '0;
            m_u_q   <= '0;
            s_t_q   <= '0;
            s_u_q   <= '0;
        end else begin
            // entering a set state below overrides this toggle
            if (tick_2hz) begin
                phase_q <= ~phase_q;
            end
            case (state_q)
                RUN: begin
                    if (tick_1hz) begin
                        h_t_q <= h_t_adv;
                        h_u_q <= h_u_adv;
                        m_t_q <= m_t_adv;
                        m_u_q <= m_u_adv;
                        s_t_q <= s_t_adv;
                        s_u_q <= s_u_adv;
                    end
                    if (mode_press) begin
                        state_q <= SET_H;
                        phase_q <= 1'b1;
                    end
                end
                SET_H: begin
                    if (mode_press) begin
                        state_q <= SET_M;
                        phase_q <= 1'b1;
                    end else if (inc_press) begin
                        h_t_q <= h_t_inc;
                        h_u_q <= h_u_inc;
                    end
                end
                SET_M: begin
                    if (mode_press) begin
                        state_q <= RUN;
                        s_t_q   <= '0;
                        s_u_q   <= '0;
                    end else if (inc_press) begin
                        m_t_q <= m_t_inc;
                        m_u_q <= m_u_inc;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scan and display
    // ------------------------------------------------------------------
    logic [2:0] idx_q;
    logic [3:0] dig;
    logic       blank;
    logic [7:0] seg_d, seg_q;
    logic [5:0] an_d, an_q;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'h40;
            4'd1:    dec7 = 7'h79;
            4'd2:    dec7 = 7'h24;
            4'd3:    dec7 = 7'h30;
            4'd4:    dec7 = 7'h19;
            4'd5:    dec7 = 7'h12;
            4'd6:    dec7 = 7'h02;
            4'd7:    dec7 = 7'h78;
            4'd8:    dec7 = 7'h00;
            4'd9:    dec7 = 7'h10;
            default: dec7 = 7'h7F;
        endcase
    endfunction

    always_comb begin
        case (idx_q)
            3'd0:    dig = h_t_q;
            3'd1:    dig = h_u_q;
            3'd2:    dig = m_t_q;
            3'd3:    dig = m_u_q;
            3'd4:    dig = s_t_q;
            default: dig = s_u_q;
        endcase
        blank = ~phase_q &&
                ((state_q == SET_H && idx_q <= 3'd1) ||
                 (state_q == SET_M && (idx_q == 3'd2 || idx_q == 3'd3)));
        seg_d = {~(idx_q == 3'd1 || idx_q == 3'd3), blank ? 7'h7F : dec7(dig)};
        an_d  = ~(6'b000001 << idx_q);
    end

    // an and seg are both derived from idx_q and latched together
    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            an_q  <= 6'b111110;
            seg_q <= 8'hC0;
        end else begin
            if (tick_1khz) begin
                idx_q <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
